fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch sequencer that drives the decode-stage instruction register's load enable and data.
- Issues one instruction-memory request at a time using a req/gnt/rvalid handshake.
- Buffers a returned instruction while decode is stalled.
- Tracks the fetch PC and handles branch redirects, discarding stale in-flight responses.
- Sits between instruction memory and the instruction register, under control of decode (stall) and execute (redirect).

Parameters:
RESET_PC, 32'h0000_0000, fetch address used after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  request address; equals fetch_pc
imem_gnt  input  1  memory accepted request this cycle (only meaningful while imem_req=1)
imem_rvalid  input  1  read data valid, one cycle pulse, at least 1 cycle after gnt
imem_rdata  input  32  instruction word, valid with imem_rvalid
stall  input  1  decode cannot consume the instruction register this cycle
redirect  input  1  branch/jump taken; one-cycle pulse
redirect_pc  input  32  new fetch address, valid with redirect
ir_en  output  1  load enable to instruction register
ir_data  output  32  data into instruction register
ir_valid  output  1  instruction register holds a valid, unconsumed instruction
ir_pc  output  32  PC of the instruction currently in the instruction register

Behaviour:
- Reset (synchronous): state=IDLE, fetch_pc=RESET_PC, drop=0, ir_valid=0, ir_pc=0, buffer=0. Outputs during reset: imem_req=0, ir_en=0, ir_data=0, imem_addr=RESET_PC. Reset overrides every other input, including a pending rvalid.
- Outputs are Moore-style plus decoded enables: imem_req=(state==REQ); imem_addr=fetch_pc.
- ir_ready = !ir_valid || !stall.
- States:
  - IDLE: go to REQ unconditionally.
  - REQ: if imem_gnt, go to WAIT; otherwise remain in REQ with the address held stable.
  - WAIT: on imem_rvalid:
    - if drop=1: clear drop, go to REQ, discard data.
    - else if ir_ready: ir_en=1, ir_data=imem_rdata, ir_pc<=fetch_pc, ir_valid<=1, fetch_pc<=fetch_pc+PC_STEP, go to REQ.
    - else: buffer<=imem_rdata, go to HOLD.
  - HOLD: when ir_ready: ir_en=1, ir_data=buffer, ir_pc<=fetch_pc, ir_valid<=1, fetch_pc<=fetch_pc+PC_STEP, go to REQ.
- ir_valid consumption: if ir_valid && !stall and no load this cycle, ir_valid<=0 (bubble). While stall=1, ir_valid, ir_pc and the instruction register are held.
- Throughput: peak one instruction per 2 cycles (REQ, WAIT) with 1-cycle memory latency. At most one request outstanding.
- Redirect has the highest priority over all non-reset events:
  - fetch_pc<=redirect_pc, ir_valid<=0, ir_en=0, buffer discarded.
  - outstanding = (state==REQ && imem_gnt) || (state==WAIT && !imem_rvalid).
  - If outstanding: go to WAIT with drop<=1. Otherwise go to REQ (this covers IDLE, HOLD, REQ without gnt, and WAIT with rvalid in the same cycle, whose data is discarded).
  - A second redirect while drop=1 only updates fetch_pc.
- Arithmetic: fetch_pc+PC_STEP is 32-bit and wraps modulo 2^32.
- ir_en is never asserted during reset, in a redirect cycle, or for dropped data.

Test Plan:
1. Reset with RESET_PC=0; gnt tied to 1; rvalid 1 cycle after gnt with rdata 0x11, 0x22, 0x33; stall=0 -> imem_addr sequence 0, 4, 8; ir_en pulses every 2nd cycle; ir_pc 0, 4, 8; ir_valid=1 each load cycle, then drops to 0 in the bubble cycle.
2. stall=1 when rvalid returns 0xDEAD (ir_valid=1) -> state HOLD, ir_en=0, no new imem_req; release stall 3 cycles later -> ir_en=1 with ir_data=0xDEAD in that cycle, ir_pc=previous+4.
3. redirect to 0x100 in WAIT before rvalid -> the next rvalid (0xBAD) causes no ir_en; then imem_addr=0x100; the next load has ir_pc=0x100.
4. redirect to 0x200 in the same cycle as rvalid -> no ir_en, ir_valid=0 next cycle, next imem_addr=0x200, drop stays 0.
5. reset asserted in WAIT, rvalid arrives during reset and one cycle after -> no ir_en; imem_req=0 for the reset cycle and the IDLE cycle; first request afterward at RESET_PC.
6. RESET_PC=32'hFFFF_FFFC -> after the first load, the second imem_addr is 32'h0000_0000 and ir_pc=32'hFFFF_FFFC.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch sequencer. Keeps one instruction-memory request in flight,
//            parks a returned word while decode stalls, and redirects on branches
//            while discarding stale responses.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ir_en,
   output logic [31:0] ir_data,
   output logic        ir_valid,
   output logic [31:0] ir_pc
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_req  = 2'd1;
   localparam logic [1:0] c_st_wait = 2'd2;
   localparam logic [1:0] c_st_hold = 2'd3;

   logic [1:0]  state_q,    state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] buffer_q,   buffer_d;
   logic [31:0] ir_pc_q,    ir_pc_d;
   logic        drop_q,     drop_d;
   logic        ir_valid_q, ir_valid_d;

   logic        w_ir_ready;
   logic        w_outstanding;
   logic        w_load_mem;
   logic        w_load_buf;
   logic        w_load;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= c_st_idle;
         fetch_pc_q <= RESET_PC;
         buffer_q   <= '0;
         ir_pc_q    <= '0;
         drop_q     <= 1'b0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         buffer_q   <= buffer_d;
         ir_pc_q    <= ir_pc_d;
         drop_q     <= drop_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      buffer_d   = buffer_q;
      ir_pc_d    = ir_pc_q;
      drop_d     = drop_q;
      ir_valid_d = ir_valid_q;
      if (redirect) begin
         // A granted-but-unreturned request must be absorbed in WAIT before refetching
         fetch_pc_d = redirect_pc;
         ir_valid_d = 1'b0;
         buffer_d   = '0;
         drop_d     = w_outstanding;
         state_d    = w_outstanding ? c_st_wait : c_st_req;
      end else begin
         case (state_q)
            c_st_idle: state_d = c_st_req;
            c_st_req: begin
               if (imem_gnt) state_d = c_st_wait;
            end
            c_st_wait: begin
               if (imem_rvalid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = c_st_req;
                  end else if (w_ir_ready) begin
                     state_d = c_st_req;
                  end else begin
                     buffer_d = imem_rdata;
                     state_d  = c_st_hold;
                  end
               end
            end
            c_st_hold: begin
               if (w_ir_ready) state_d = c_st_req;
            end
            default: state_d = c_st_idle;
         endcase
         if (w_load) begin
            ir_valid_d = 1'b1;
            ir_pc_d    = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end else if (ir_valid_q && !stall) begin
            ir_valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      w_ir_ready    = !ir_valid_q || !stall;
      w_outstanding = ((state_q == c_st_req) && imem_gnt) ||
                      ((state_q == c_st_wait) && !imem_rvalid);
      w_load_mem    = (state_q == c_st_wait) && imem_rvalid && !drop_q && w_ir_ready &&
                      !redirect && !reset;
      w_load_buf    = (state_q == c_st_hold) && w_ir_ready && !redirect && !reset;
      w_load        = w_load_mem || w_load_buf;
      imem_req      = (state_q == c_st_req) && !reset;
      imem_addr     = reset ? RESET_PC : fetch_pc_q;
      ir_en         = w_load;
      ir_data       = w_load_buf ? buffer_q : (w_load_mem ? imem_rdata : 32'h0);
   end

   assign ir_valid = ir_valid_q;
   assign ir_pc    = ir_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Scenario bench for fetch_ctrl with an expected-load scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        imem_req,    wr_imem_req;
   logic [31:0] imem_addr,   wr_imem_addr;
   logic        ir_en,       wr_ir_en;
   logic [31:0] ir_data,     wr_ir_data;
   logic        ir_valid,    wr_ir_valid;
   logic [31:0] ir_pc,       wr_ir_pc;

   exp_t sb_q[$];
   int   n_cmp;
   int   n_mis;

   fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .ir_en(ir_en), .ir_data(ir_data), .ir_valid(ir_valid), .ir_pc(ir_pc)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_w (
      .clk(clk), .reset(reset),
      .imem_req(wr_imem_req), .imem_addr(wr_imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .ir_en(wr_ir_en), .ir_data(wr_ir_data), .ir_valid(wr_ir_valid), .ir_pc(wr_ir_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      n_cmp++; if (ir_en !== 1'b0) begin n_mis++; $display("FAIL reset_ir_en: got %0b want 0", ir_en); end
      n_cmp++; if (ir_data !== 32'h0) begin n_mis++; $display("FAIL reset_ir_data: got %h want 0", ir_data); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_mis++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      n_cmp++; if (wr_imem_addr !== 32'hFFFF_FFFC) begin n_mis++; $display("FAIL reset_addr_w: got %h want fffffffc", wr_imem_addr); end
      n_cmp++; if (ir_valid !== 1'b0 || ir_pc !== 32'h0) begin n_mis++; $display("FAIL reset_ir: got valid=%0b pc=%h want 0/0", ir_valid, ir_pc); end
      tick();
   endtask

   task automatic test_basic();
      exp_t        e;
      logic [31:0] pc_exp;
      pc_exp   = 32'h0;
      reset    = 1'b0;
      imem_gnt = 1'b1;
      stall    = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL basic_idle_req: got %0b want 0", imem_req); end
      tick();
      for (int i = 0; i < 3; i++) begin
         imem_rvalid = 1'b0;
         #1;
         n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin n_mis++; $display("FAIL basic_req: got req=%0b addr=%h want 1/%h", imem_req, imem_addr, 32'(i * 4)); end
         n_cmp++; if (ir_en !== 1'b0) begin n_mis++; $display("FAIL basic_req_ir_en: got %0b want 0", ir_en); end
         if (i > 0) begin
            n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== pc_exp) begin n_mis++; $display("FAIL basic_ir_pc: got valid=%0b pc=%h want 1/%h", ir_valid, ir_pc, pc_exp); end
         end
         tick();
         n_cmp++; if (ir_valid !== 1'b0) begin n_mis++; $display("FAIL basic_bubble: got ir_valid=%0b want 0", ir_valid); end
         imem_rvalid = 1'b1;
         imem_rdata  = 32'h11 * 32'(i + 1);
         e.data = imem_rdata;
         e.pc   = 32'(i * 4);
         sb_q.push_back(e);
         #1;
         n_cmp++;
         if (ir_en !== 1'b1 || sb_q.size() == 0) begin n_mis++; $display("FAIL basic_load: got ir_en=%0b want 1", ir_en); end
         else begin
            e = sb_q.pop_front();
            n_cmp++; if (ir_data !== e.data) begin n_mis++; $display("FAIL basic_data: got %h want %h", ir_data, e.data); end
            pc_exp = e.pc;
         end
         tick();
      end
      imem_rvalid = 1'b0;
      #1;
      n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== pc_exp || imem_addr !== 32'hC) begin n_mis++; $display("FAIL basic_last: got valid=%0b pc=%h addr=%h want 1/%h/c", ir_valid, ir_pc, imem_addr, pc_exp); end
      tick();
   endtask

   task automatic test_stall();
      exp_t e;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h44;
      e.data = 32'h44; e.pc = 32'hC;
      sb_q.push_back(e);
      #1;
      n_cmp++;
      if (ir_en !== 1'b1 || sb_q.size() == 0) begin n_mis++; $display("FAIL stall_pre_load: got ir_en=%0b want 1", ir_en); end
      else begin
         e = sb_q.pop_front();
         n_cmp++; if (ir_data !== e.data) begin n_mis++; $display("FAIL stall_pre_data: got %h want %h", ir_data, e.data); end
      end
      tick();
      imem_rvalid = 1'b0;
      stall       = 1'b1;
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_DEAD;
      #1;
      n_cmp++; if (ir_en !== 1'b0) begin n_mis++; $display("FAIL stall_rvalid_ir_en: got %0b want 0", ir_en); end
      tick();
      imem_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if (imem_req !== 1'b0 || ir_en !== 1'b0) begin n_mis++; $display("FAIL stall_hold: got req=%0b ir_en=%0b want 0/0", imem_req, ir_en); end
         n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== 32'hC) begin n_mis++; $display("FAIL stall_held_ir: got valid=%0b pc=%h want 1/c", ir_valid, ir_pc); end
         tick();
      end
      stall = 1'b0;
      e.data = 32'h0000_DEAD; e.pc = 32'h10;
      sb_q.push_back(e);
      #1;
      n_cmp++;
      if (ir_en !== 1'b1 || sb_q.size() == 0) begin n_mis++; $display("FAIL stall_release: got ir_en=%0b want 1", ir_en); end
      else begin
         e = sb_q.pop_front();
         n_cmp++; if (ir_data !== e.data) begin n_mis++; $display("FAIL stall_release_data: got %h want %h", ir_data, e.data); end
      end
      tick();
      #1;
      n_cmp++; if (ir_pc !== 32'h10 || ir_valid !== 1'b1) begin n_mis++; $display("FAIL stall_ir_pc: got pc=%h valid=%0b want 10/1", ir_pc, ir_valid); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin n_mis++; $display("FAIL stall_next_req: got req=%0b addr=%h want 1/14", imem_req, imem_addr); end
      tick();
   endtask

   task automatic test_redirect_wait();
      exp_t e;
      redirect    = 1'b1;
      redirect_pc = 32'hF0;
      #1;
      n_cmp++; if (ir_en !== 1'b0) begin n_mis++; $display("FAIL redir_wait_ir_en: got %0b want 0", ir_en); end
      tick();
      redirect_pc = 32'h100;
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL redir_second_req: got %0b want 0", imem_req); end
      tick();
      redirect    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0BAD;
      #1;
      n_cmp++; if (ir_en !== 1'b0) begin n_mis++; $display("FAIL redir_drop_ir_en: got %0b want 0", ir_en); end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_mis++; $display("FAIL redir_new_req: got req=%0b addr=%h want 1/100", imem_req, imem_addr); end
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h55;
      e.data = 32'h55; e.pc = 32'h100;
      sb_q.push_back(e);
      #1;
      n_cmp++;
      if (ir_en !== 1'b1 || sb_q.size() == 0) begin n_mis++; $display("FAIL redir_load: got ir_en=%0b want 1", ir_en); end
      else begin
         e = sb_q.pop_front();
         n_cmp++; if (ir_data !== e.data) begin n_mis++; $display("FAIL redir_data: got %h want %h", ir_data, e.data); end
      end
      tick();
      imem_rvalid = 1'b0;
      stall       = 1'b1;
      #1;
      n_cmp++; if (ir_pc !== 32'h100 || ir_valid !== 1'b1 || imem_addr !== 32'h104) begin n_mis++; $display("FAIL redir_ir_pc: got pc=%h valid=%0b addr=%h want 100/1/104", ir_pc, ir_valid, imem_addr); end
      tick();
   endtask

   task automatic test_redirect_rvalid();
      exp_t e;
      stall       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h66;
      #1;
      n_cmp++; if (ir_en !== 1'b0) begin n_mis++; $display("FAIL redir_rv_ir_en: got %0b want 0", ir_en); end
      tick();
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      #1;
      n_cmp++; if (ir_valid !== 1'b0) begin n_mis++; $display("FAIL redir_rv_valid: got %0b want 0", ir_valid); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_mis++; $display("FAIL redir_rv_req: got req=%0b addr=%h want 1/200", imem_req, imem_addr); end
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h77;
      e.data = 32'h77; e.pc = 32'h200;
      sb_q.push_back(e);
      #1;
      n_cmp++;
      if (ir_en !== 1'b1 || sb_q.size() == 0) begin n_mis++; $display("FAIL redir_rv_load: got ir_en=%0b want 1", ir_en); end
      else begin
         e = sb_q.pop_front();
         n_cmp++; if (ir_data !== e.data) begin n_mis++; $display("FAIL redir_rv_data: got %h want %h", ir_data, e.data); end
      end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_cmp++; if (ir_pc !== 32'h200) begin n_mis++; $display("FAIL redir_rv_ir_pc: got %h want 200", ir_pc); end
      tick();
   endtask

   task automatic test_reset_wait();
      exp_t e;
      reset       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h99;
      #1;
      n_cmp++; if (ir_en !== 1'b0 || imem_req !== 1'b0) begin n_mis++; $display("FAIL rstw_outputs: got ir_en=%0b req=%0b want 0/0", ir_en, imem_req); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_mis++; $display("FAIL rstw_addr: got %h want 0", imem_addr); end
      tick();
      reset      = 1'b0;
      imem_rdata = 32'h9A;
      #1;
      n_cmp++; if (ir_en !== 1'b0 || imem_req !== 1'b0) begin n_mis++; $display("FAIL rstw_idle: got ir_en=%0b req=%0b want 0/0", ir_en, imem_req); end
      n_cmp++; if (ir_valid !== 1'b0 || ir_pc !== 32'h0) begin n_mis++; $display("FAIL rstw_ir: got valid=%0b pc=%h want 0/0", ir_valid, ir_pc); end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_mis++; $display("FAIL rstw_first_req: got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hAB;
      e.data = 32'hAB; e.pc = 32'h0;
      sb_q.push_back(e);
      #1;
      n_cmp++;
      if (ir_en !== 1'b1 || sb_q.size() == 0) begin n_mis++; $display("FAIL rstw_load: got ir_en=%0b want 1", ir_en); end
      else begin
         e = sb_q.pop_front();
         n_cmp++; if (ir_data !== e.data) begin n_mis++; $display("FAIL rstw_data: got %h want %h", ir_data, e.data); end
      end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_cmp++; if (ir_pc !== 32'h0 || imem_addr !== 32'h4) begin n_mis++; $display("FAIL rstw_after: got pc=%h addr=%h want 0/4", ir_pc, imem_addr); end
      tick();
   endtask

   task automatic test_wrap();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      #1;
      n_cmp++; if (wr_imem_req !== 1'b1 || wr_imem_addr !== 32'hFFFF_FFFC) begin n_mis++; $display("FAIL wrap_req: got req=%0b addr=%h want 1/fffffffc", wr_imem_req, wr_imem_addr); end
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hC0;
      #1;
      n_cmp++; if (wr_ir_en !== 1'b1 || wr_ir_data !== 32'hC0) begin n_mis++; $display("FAIL wrap_load: got ir_en=%0b data=%h want 1/c0", wr_ir_en, wr_ir_data); end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_cmp++; if (wr_imem_addr !== 32'h0) begin n_mis++; $display("FAIL wrap_addr: got %h want 0", wr_imem_addr); end
      n_cmp++; if (wr_ir_pc !== 32'hFFFF_FFFC || wr_ir_valid !== 1'b1) begin n_mis++; $display("FAIL wrap_ir_pc: got pc=%h valid=%0b want fffffffc/1", wr_ir_pc, wr_ir_valid); end
      tick();
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      reset       = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_redirect_rvalid();
      test_reset_wait();
      test_wrap();
      n_cmp++; if (sb_q.size() != 0) begin n_mis++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
